// File: rtl/alu_execution_unit_if.sv
// rtl/alu_execution_unit_if.sv - dispatch and result channels between reservation station, ALU and CDB arbiter
interface alu_execution_unit_if #(
    parameter int BW_PROCESSOR_DATA = 32,
    parameter int BW_OPCODE_INT     = 3,
    parameter int BW_TAG            = 3
);
    logic                           i_rs_valid;
    logic                           i_rs_ready;
    logic [BW_OPCODE_INT-1:0]       i_rs_opcode;
    logic [BW_TAG-1:0]              i_rs_tag;
    logic [2*BW_PROCESSOR_DATA-1:0] i_rs_V_flatten;
    logic                           o_cdb_valid;
    logic                           o_cdb_ready;
    logic [BW_TAG-1:0]              o_cdb_tag;
    logic [BW_PROCESSOR_DATA-1:0]   o_cdb_data;

    // Reservation station / arbiter side
    modport master (
        output i_rs_valid, i_rs_opcode, i_rs_tag, i_rs_V_flatten, o_cdb_ready,
        input  i_rs_ready, o_cdb_valid, o_cdb_tag, o_cdb_data
    );

    // Execution unit side
    modport slave (
        input  i_rs_valid, i_rs_opcode, i_rs_tag, i_rs_V_flatten, o_cdb_ready,
        output i_rs_ready, o_cdb_valid, o_cdb_tag, o_cdb_data
    );
endinterface

// File: rtl/alu_execution_unit.sv
// rtl/alu_execution_unit.sv - integer ALU execution stage with single-cycle ops and iterative MUL
module alu_execution_unit #(
    parameter int BW_PROCESSOR_DATA = 32,
    parameter int BW_OPCODE_INT     = 3,
    parameter int BW_TAG            = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_execution_unit_if.slave  bus
);
    localparam int BW  = BW_PROCESSOR_DATA;
    localparam int SHW = $clog2(BW);
    localparam int CW  = $clog2(BW);

    localparam logic [BW_OPCODE_INT-1:0] OP_ADD = BW_OPCODE_INT'(0);
    localparam logic [BW_OPCODE_INT-1:0] OP_SUB = BW_OPCODE_INT'(1);
    localparam logic [BW_OPCODE_INT-1:0] OP_AND = BW_OPCODE_INT'(2);
    localparam logic [BW_OPCODE_INT-1:0] OP_OR  = BW_OPCODE_INT'(3);
    localparam logic [BW_OPCODE_INT-1:0] OP_XOR = BW_OPCODE_INT'(4);
    localparam logic [BW_OPCODE_INT-1:0] OP_SLL = BW_OPCODE_INT'(5);
    localparam logic [BW_OPCODE_INT-1:0] OP_SRA = BW_OPCODE_INT'(6);
    localparam logic [BW_OPCODE_INT-1:0] OP_MUL = BW_OPCODE_INT'(7);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [BW-1:0]      mcand_q;
    logic [BW-1:0]      mplier_q;
    logic [BW-1:0]      prod_q;
    logic [CW-1:0]      cnt_q;
    logic [BW_TAG-1:0]  mtag_q;

    logic               cdb_valid_q;
    logic [BW_TAG-1:0]  cdb_tag_q;
    logic [BW-1:0]      cdb_data_q;

    logic [BW-1:0]      op_a;
    logic [BW-1:0]      op_b;
    logic [SHW-1:0]     shamt;
    logic               accept;
    logic               is_mul;
    logic               last_step;
    logic [BW-1:0]      alu_res;
    logic [BW-1:0]      prod_step;

    assign op_a      = bus.i_rs_V_flatten[BW-1:0];
    assign op_b      = bus.i_rs_V_flatten[2*BW-1:BW];
    assign shamt     = op_b[SHW-1:0];
    assign is_mul    = (bus.i_rs_opcode == OP_MUL);
    assign last_step = (cnt_q == CW'(BW-1));
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

    // Dispatch is open only when idle and the output slot is free or draining this edge
    assign bus.i_rs_ready = (state_q == IDLE) && (!cdb_valid_q || bus.o_cdb_ready);
    assign accept         = bus.i_rs_valid && bus.i_rs_ready;

    assign bus.o_cdb_valid = cdb_valid_q;
    assign bus.o_cdb_tag   = cdb_tag_q;
    assign bus.o_cdb_data  = cdb_data_q;

    // Single-cycle operation result from the live dispatch operands
    always_comb begin
        alu_res = '0;
        case (bus.i_rs_opcode)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRA:  alu_res = $signed(op_a) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: MUL accepts enter the busy loop, the final step returns to idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept && is_mul) state_d = MUL_BUSY;
            MUL_BUSY: if (last_step) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath: output register, operand latches and shift-add iteration
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            mtag_q      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else if (state_q == IDLE) begin
            if (accept) begin
                if (is_mul) begin
                    mcand_q     <= op_a;
                    mplier_q    <= op_b;
                    prod_q      <= '0;
                    cnt_q       <= '0;
                    mtag_q      <= bus.i_rs_tag;
                    // Accepting implies any pending result drains on this edge
                    cdb_valid_q <= 1'b0;
                end else begin
                    cdb_valid_q <= 1'b1;
                    cdb_tag_q   <= bus.i_rs_tag;
                    cdb_data_q  <= alu_res;
                end
            end else if (cdb_valid_q && bus.o_cdb_ready) begin
                cdb_valid_q <= 1'b0;
            end
        end else begin
            prod_q   <= prod_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            // Output slot is known empty while busy, so the final product loads directly
            if (last_step) begin
                cdb_valid_q <= 1'b1;
                cdb_tag_q   <= mtag_q;
                cdb_data_q  <= prod_step;
            end
        end
    end
endmodule

// File: tb/tb_alu_execution_unit.sv
// tb/tb_alu_execution_unit.sv - self-checking bench for alu_execution_unit
module tb_alu_execution_unit;
    typedef struct {
        logic [2:0]  tag;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    exp_t expq[$];
    int   deliv_cycs[$];
    int   deliv_count = 0;
    int   valid_rise_cyc = 0;
    logic [31:0] last_data = '0;
    logic [2:0]  last_tag = '0;
    bit   mul_pending = 0;

    bit          prev_valid = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_data = '0;
    logic [2:0]  prev_tag = '0;

    alu_execution_unit_if bus ();

    alu_execution_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << b[4:0];
            3'd6: return $signed(a) >>> b[4:0];
            default: return a * b;
        endcase
    endfunction

    // Per-cycle comparison of the result channel against the model queue
    always begin
        @(negedge clk);
        #3;
        if (rst) begin
            prev_valid = 0;
            prev_hold  = 0;
        end else begin
            if (prev_hold)
                check(bus.o_cdb_valid && bus.o_cdb_tag == prev_tag && bus.o_cdb_data == prev_data,
                      "stall_hold", bus.o_cdb_data, prev_data);
            if (bus.o_cdb_valid && !prev_valid) valid_rise_cyc = cyc;
            if (mul_pending) begin
                if (bus.o_cdb_valid) mul_pending = 0;
                else check(bus.i_rs_ready == 1'b0, "busy_ready", 32'(bus.i_rs_ready), 32'd0);
            end
            if (bus.o_cdb_valid && bus.o_cdb_ready) begin
                if (expq.size() == 0) begin
                    check(1'b0, "unexpected_result", bus.o_cdb_data, 32'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check(bus.o_cdb_tag == e.tag, "result_tag", 32'(bus.o_cdb_tag), 32'(e.tag));
                    check(bus.o_cdb_data == e.data, "result_data", bus.o_cdb_data, e.data);
                end
                last_data = bus.o_cdb_data;
                last_tag  = bus.o_cdb_tag;
                deliv_cycs.push_back(cyc);
                deliv_count++;
            end
            prev_hold  = bus.o_cdb_valid && !bus.o_cdb_ready;
            prev_tag   = bus.o_cdb_tag;
            prev_data  = bus.o_cdb_data;
            prev_valid = bus.o_cdb_valid;
        end
    end

    task automatic dispatch(input logic [2:0] op, input logic [2:0] tag, input logic [31:0] a,
                            input logic [31:0] b, output int acc);
        int n;
        exp_t e;
        @(negedge clk);
        #1;
        bus.i_rs_valid     = 1'b1;
        bus.i_rs_opcode    = op;
        bus.i_rs_tag       = tag;
        bus.i_rs_V_flatten = {b, a};
        #1;
        n = 0;
        while (!bus.i_rs_ready && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!bus.i_rs_ready) begin
            check(1'b0, "dispatch_timeout", 32'(n), 32'd200);
            bus.i_rs_valid = 1'b0;
            acc = -1;
        end else begin
            e.tag  = tag;
            e.data = model(op, a, b);
            expq.push_back(e);
            @(posedge clk);
            #1;
            acc = cyc;
            if (op == 3'd7) mul_pending = 1;
            bus.i_rs_valid     = 1'b0;
            bus.i_rs_opcode    = 3'($urandom_range(0, 7));
            bus.i_rs_V_flatten = {$urandom, $urandom};
        end
    endtask

    task automatic wait_deliv(input int target);
        int n;
        n = 0;
        while (deliv_count < target && n < 200) begin
            @(negedge clk);
            #4;
            n++;
        end
        if (deliv_count < target) check(1'b0, "delivery_timeout", 32'(deliv_count), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, base;
        int accs[4];
        rst                = 1'b1;
        bus.i_rs_valid     = 1'b0;
        bus.i_rs_opcode    = '0;
        bus.i_rs_tag       = '0;
        bus.i_rs_V_flatten = '0;
        bus.o_cdb_ready    = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check(bus.o_cdb_valid == 1'b0, "reset_valid", 32'(bus.o_cdb_valid), 32'd0);
        check(bus.o_cdb_data == 32'd0, "reset_data", bus.o_cdb_data, 32'd0);
        check(bus.o_cdb_tag == 3'd0, "reset_tag", 32'(bus.o_cdb_tag), 32'd0);
        check(bus.i_rs_ready == 1'b1, "reset_ready", 32'(bus.i_rs_ready), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check(bus.o_cdb_valid == 1'b0 && bus.i_rs_ready == 1'b1, "idle_after_reset",
              32'({bus.o_cdb_valid, bus.i_rs_ready}), 32'b01);

        // Single-cycle ops with literal expectations
        dispatch(3'd0, 3'd5, 32'h7FFF_FFFF, 32'd1, acc);
        wait_deliv(1);
        check(last_data == 32'h8000_0000, "add_overflow", last_data, 32'h8000_0000);
        check(last_tag == 3'd5, "add_tag", 32'(last_tag), 32'd5);
        check(valid_rise_cyc == acc, "simple_latency", 32'(valid_rise_cyc - acc), 32'd0);
        dispatch(3'd1, 3'd1, 32'd3, 32'd5, acc);
        wait_deliv(2);
        check(last_data == 32'hFFFF_FFFE, "sub_neg", last_data, 32'hFFFF_FFFE);
        dispatch(3'd6, 3'd3, 32'h8000_0000, 32'd4, acc);
        wait_deliv(3);
        check(last_data == 32'hF800_0000, "sra", last_data, 32'hF800_0000);
        dispatch(3'd5, 3'd4, 32'd1, 32'd33, acc);
        wait_deliv(4);
        check(last_data == 32'h0000_0002, "sll_wrap_shamt", last_data, 32'h2);
        dispatch(3'd2, 3'd6, 32'hF0F0_1234, 32'h0FF0_FFFF, acc);
        dispatch(3'd3, 3'd7, 32'hF000_0000, 32'h0000_000F, acc);
        wait_deliv(6);

        // Back-to-back XOR stream
        base = deliv_count;
        for (int i = 0; i < 4; i++)
            dispatch(3'd4, 3'(i), 32'hA5A5_0000 + 32'(i * 3), 32'h1111_1111 << i, accs[i]);
        wait_deliv(base + 4);
        for (int i = 1; i < 4; i++) begin
            check(accs[i] == accs[i-1] + 1, "xor_accept_gap", 32'(accs[i] - accs[i-1]), 32'd1);
            check(deliv_cycs[base+i] == deliv_cycs[base+i-1] + 1, "xor_result_gap",
                  32'(deliv_cycs[base+i] - deliv_cycs[base+i-1]), 32'd1);
        end

        // Stall with a waiting dispatch, then drain and accept on one edge
        @(negedge clk);
        #1;
        bus.o_cdb_ready = 1'b0;
        base = deliv_count;
        dispatch(3'd0, 3'd6, 32'd100, 32'd23, acc);
        fork
            dispatch(3'd1, 3'd7, 32'd50, 32'd80, acc2);
            begin
                repeat (3) begin
                    @(negedge clk);
                    #2;
                    check(bus.i_rs_ready == 1'b0, "stall_ready", 32'(bus.i_rs_ready), 32'd0);
                end
                @(negedge clk);
                #1;
                bus.o_cdb_ready = 1'b1;
            end
        join
        wait_deliv(base + 2);
        check(deliv_cycs[base] + 1 == acc2, "drain_accept_same_edge", 32'(acc2 - deliv_cycs[base]), 32'd1);
        check(last_data == 32'hFFFF_FFE2, "sub_after_stall", last_data, 32'hFFFF_FFE2);

        // Multiply
        dispatch(3'd7, 3'd2, 32'hFFFF_FFF9, 32'd6, acc);
        wait_deliv(base + 3);
        check(last_data == 32'hFFFF_FFD6, "mul_neg", last_data, 32'hFFFF_FFD6);
        check(last_tag == 3'd2, "mul_tag", 32'(last_tag), 32'd2);
        check(valid_rise_cyc - acc == 32, "mul_latency", 32'(valid_rise_cyc - acc), 32'd32);
        dispatch(3'd7, 3'd3, 32'h0001_0000, 32'h0001_0000, acc);
        wait_deliv(base + 4);
        check(last_data == 32'd0, "mul_wrap", last_data, 32'd0);
        dispatch(3'd7, 3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, acc);
        wait_deliv(base + 5);
        check(last_data == 32'd15, "mul_negneg", last_data, 32'd15);

        // MUL dispatched while an ADD result is stalled
        @(negedge clk);
        #1;
        bus.o_cdb_ready = 1'b0;
        base = deliv_count;
        dispatch(3'd0, 3'd4, 32'd10, 32'd20, acc);
        fork
            dispatch(3'd7, 3'd5, 32'd100, 32'hFFFF_FFFD, acc2);
            begin
                repeat (3) @(negedge clk);
                #1;
                bus.o_cdb_ready = 1'b1;
            end
        join
        wait_deliv(base + 2);
        check(deliv_cycs[base] + 1 == acc2, "add_before_mul", 32'(acc2 - deliv_cycs[base]), 32'd1);
        check(last_data == 32'hFFFF_FED4, "mul_after_stall", last_data, 32'hFFFF_FED4);
        check(valid_rise_cyc - acc2 == 32, "mul_latency_stall", 32'(valid_rise_cyc - acc2), 32'd32);

        // Asynchronous reset in the middle of a multiply
        base = deliv_count;
        dispatch(3'd7, 3'd6, 32'd9, 32'd9, acc);
        repeat (9) @(negedge clk);
        #1;
        rst = 1'b1;
        expq.delete();
        mul_pending = 0;
        #1;
        check(bus.o_cdb_valid == 1'b0, "async_reset_valid", 32'(bus.o_cdb_valid), 32'd0);
        check(bus.o_cdb_data == 32'd0, "async_reset_data", bus.o_cdb_data, 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check(bus.i_rs_ready == 1'b1, "ready_after_reset", 32'(bus.i_rs_ready), 32'd1);
        repeat (40) @(negedge clk);
        #4;
        check(deliv_count == base && bus.o_cdb_valid == 1'b0, "mul_discarded", 32'(deliv_count - base), 32'd0);
        dispatch(3'd0, 3'd1, 32'd1, 32'd2, acc);
        wait_deliv(base + 1);
        check(last_data == 32'd3, "add_after_reset", last_data, 32'd3);
        check(expq.size() == 0, "queue_empty", 32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_execution_unit.md
Name: alu_execution_unit

Overview:
- Integer ALU execution stage; the consumer end of the reservation-station-to-execution valid/ready channel.
- Accepts one dispatched instruction at a time: opcode, destination tag and two resolved operands.
- Computes the result and presents it with its tag on a valid/ready channel toward the common-data-bus arbiter.
- Simple ops take one cycle; MUL is iterative and multi-cycle, so the block exercises dispatch back-pressure.

Parameters:
BW_PROCESSOR_DATA, 32, operand/result width
BW_OPCODE_INT, 3, opcode width
BW_TAG, 3, reservation-station tag width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
i_rs_valid  in  1  dispatch valid from reservation station
i_rs_ready  out  1  unit can accept dispatch this cycle
i_rs_opcode  in  BW_OPCODE_INT  operation
i_rs_tag  in  BW_TAG  destination tag
i_rs_V_flatten  in  2*BW_PROCESSOR_DATA  signed; A=[BW-1:0], B=[2BW-1:BW]
o_cdb_valid  out  1  result valid
o_cdb_ready  in  1  arbiter accepts result
o_cdb_tag  out  BW_TAG  tag of result
o_cdb_data  out  BW_PROCESSOR_DATA  signed result

Behaviour:
- Reset (async, any state including mid-MUL): state=IDLE, o_cdb_valid=0, o_cdb_tag=0, o_cdb_data=0, iteration counter=0, operand regs=0. In-flight work is discarded.
- Opcodes (result truncated to BW, two's complement wrap):
  - 0 ADD A+B
  - 1 SUB A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLL A<<B[$clog2(BW)-1:0]
  - 6 SRA A>>>B[$clog2(BW)-1:0]
  - 7 MUL low BW bits of A*B
- Handshake:
  - Transfer occurs on a rising edge where valid&&ready on that channel.
  - i_rs_ready = (state==IDLE) && (!o_cdb_valid || o_cdb_ready); purely combinational, no dependence on i_rs_valid.
  - o_cdb_valid/tag/data are registered and held stable while o_cdb_valid && !o_cdb_ready.
- FSM:
  - IDLE, simple-op accept: o_cdb_* loaded on the accept edge; o_cdb_valid=1 next cycle (latency 1). Back-to-back accepts give 1 result per cycle while o_cdb_ready=1.
  - IDLE, MUL accept: latch A as multiplicand, B as multiplier, latch tag, product=0, counter=0; go to MUL_BUSY. If o_cdb_valid was set, it clears on this edge, since accept implies the drain is occurring.
  - MUL_BUSY: each edge does one radix-2 shift-add step (if multiplier LSB, product+=multiplicand; multiplicand<<=1; multiplier>>=1) and increments the counter. i_rs_ready=0 throughout.
  - On the step where the counter reaches BW-1: o_cdb_data=final product, o_cdb_tag=latched tag, o_cdb_valid=1; return to IDLE. MUL latency = BW cycles from accept edge to valid (32 default). The output register is guaranteed empty during MUL_BUSY.
- Drain with no new accept: o_cdb_valid clears on the edge o_cdb_ready=1.
- Simultaneous drain and accept: old result leaves, new result (simple op) loads on the same edge; no bubble, no loss.
- i_rs_valid with i_rs_ready=0: ignored. The sender must hold its payload; the unit samples nothing.
- Opcode and operands are sampled only on the accept edge; later input changes have no effect.
- Signed overflow is not flagged.

Test Plan:
- Reset then idle -> o_cdb_valid=0, o_cdb_data=0, i_rs_ready=1; assert rst while MUL_BUSY at cycle 10 -> IDLE, o_cdb_valid=0, i_rs_ready=1 after release.
- ADD A=0x7FFFFFFF B=1 tag 5, o_cdb_ready=1 -> next cycle valid, data=0x80000000, tag 5. SUB A=3 B=5 -> 0xFFFFFFFE. SRA A=0x80000000 B=4 -> 0xF8000000. SLL A=1 B=33 -> 0x2.
- Stream of 4 XORs with o_cdb_ready=1 -> 4 results on 4 consecutive cycles, tags in order. Hold o_cdb_ready=0 for 3 cycles -> data/tag stable, i_rs_ready=0; release -> drain and new accept on the same edge.
- MUL A=-7 B=6 tag 2 -> i_rs_ready=0 for 32 cycles, then o_cdb_valid=1, data=0xFFFFFFD6 (-42), tag 2; MUL 0x10000 x 0x10000 -> 0x0.
- Dispatch MUL while an ADD result is stalled -> MUL not accepted until o_cdb_ready=1; ADD result delivered first, then MUL result 32 cycles after its accept edge.
